// File: rtl/display_scan.sv
// display_scan
//
// Time-multiplexed scanner for an eight-digit (configurable) seven-segment
// display. A 32-bit (4*DIGITS) hex value is double-buffered: "load" captures
// it into a pending register, and the pending value is committed to the
// displayed (shadow) register only at a frame boundary, so a frame never
// shows a mix of old and new digits. One nibble at a time is presented on
// "numero" for the downstream segment decoder, together with the matching
// active-low anode on "an".
//
// Optional feature: define DISPLAY_SCAN_LZB_EN to enable leading-zero
// blanking. Without it, every enabled digit is lit, including leading zeros.
//
// Parameters
//   DIGITS       number of multiplexed digits (1..8)
//   REFRESH_DIV  clock cycles each digit stays lit (>= 2)
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   valor      value to display, nibble 0 is the rightmost digit
//   load       single-cycle strobe capturing valor into the pending register
//   en         per-digit enable, 0 forces that digit dark
//   numero     nibble of the digit currently scanned
//   an         anode select, active-low, at most one bit low
//   frame      one-cycle pulse on the cycle after a shadow commit
//   pendiente  high while a loaded value waits for the frame boundary

module display_scan #(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   valor,
  input  logic                  load,
  input  logic [DIGITS-1:0]     en,
  output logic [3:0]            numero,
  output logic [DIGITS-1:0]     an,
  output logic                  frame,
  output logic                  pendiente
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic                  tick;
  logic                  boundary;
  logic [4*DIGITS-1:0]   shadow;
  logic [4*DIGITS-1:0]   pend;
  logic [DIGITS-1:0]     lit;
  logic [DIGITS-1:0]     an_next;
  logic [3:0]            numero_next;

  assign tick     = (cnt == CNT_LAST);
  assign boundary = tick && (idx == IDX_LAST);

  // Refresh divider and digit index. The index only moves on the last cycle
  // of a digit period, and the frame ends when the last digit finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      if (tick) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Double buffer. A load on the boundary cycle itself bypasses the pending
  // register and commits straight away, so pendiente never rises for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= '0;
      shadow    <= '0;
      pendiente <= 1'b0;
      frame     <= 1'b0;
    end else begin
      if (load) begin
        pend <= valor;
      end
      if (boundary && (pendiente || load)) begin
        shadow    <= load ? valor : pend;
        pendiente <= 1'b0;
        frame     <= 1'b1;
      end else begin
        frame <= 1'b0;
        if (load) begin
          pendiente <= 1'b1;
        end
      end
    end
  end

`ifdef DISPLAY_SCAN_LZB_EN
  // A digit above digit 0 goes dark when it and every more significant
  // nibble of the displayed value are zero.
  logic [DIGITS-1:0] lzb_dark;

  always_comb begin
    lzb_dark = '0;
    for (int i = 1; i < DIGITS; i++) begin
      lzb_dark[i] = ((shadow >> (4 * i)) == '0);
    end
  end

  assign lit = en & ~lzb_dark;
`else
  assign lit = en;
`endif

  // Next output values from the current index and displayed value. numero is
  // driven even when the digit is dark.
  always_comb begin
    numero_next = shadow[4*idx +: 4];
    an_next     = '1;
    if (lit[idx]) begin
      an_next[idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      numero <= '0;
      an     <= '1;
    end else begin
      numero <= numero_next;
      an     <= an_next;
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan
//
// Self-checking bench for display_scan with DIGITS=8, REFRESH_DIV=4.
// Stimulus tasks drive one clock edge at a time and push the expected
// post-edge outputs into a scoreboard queue; a monitor on the falling edge
// pops and compares. Edge k (counted from reset release, first edge is 1)
// shows digit ((k-1)/4)%8 and is a frame boundary when k%32 == 0.

module tb_display_scan;

  localparam int D = 8;
  localparam int R = 4;
  localparam int FRAME = D * R;

  logic        clk;
  logic        rst_n;
  logic [31:0] valor;
  logic        load;
  logic [7:0]  en;
  logic [3:0]  numero;
  logic [7:0]  an;
  logic        frame;
  logic        pendiente;

  typedef struct packed {
    int         k;
    logic [3:0] numero;
    logic [7:0] an;
    logic       frame;
    logic       pendiente;
  } exp_t;

  exp_t sb[$];

  int tests;
  int failures;
  int k;

  logic [31:0] m_shadow;
  logic [31:0] m_pend;
  logic        m_pendiente;

  display_scan #(
    .DIGITS(D),
    .REFRESH_DIV(R)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .valor(valor),
    .load(load),
    .en(en),
    .numero(numero),
    .an(an),
    .frame(frame),
    .pendiente(pendiente)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input exp_t e);
    tests++;
    if (numero !== e.numero) begin
      failures++;
      $display("[TB] FAIL numero edge %0d: got %h expected %h", e.k, numero, e.numero);
    end
    tests++;
    if (an !== e.an) begin
      failures++;
      $display("[TB] FAIL an edge %0d: got %h expected %h", e.k, an, e.an);
    end
    tests++;
    if (frame !== e.frame) begin
      failures++;
      $display("[TB] FAIL frame edge %0d: got %b expected %b", e.k, frame, e.frame);
    end
    tests++;
    if (pendiente !== e.pendiente) begin
      failures++;
      $display("[TB] FAIL pendiente edge %0d: got %b expected %b", e.k, pendiente, e.pendiente);
    end
  endtask

  // Monitor: compare whatever the stimulus side said this cycle should show.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkOutput(e);
    end
  end

  function automatic exp_t resetExp();
    exp_t e;
    e.k = -1;
    e.numero = 4'h0;
    e.an = 8'hFF;
    e.frame = 1'b0;
    e.pendiente = 1'b0;
    return e;
  endfunction

  // One clock edge with the given inputs; expectation pushed for after it.
  task automatic applyStimulus(input logic ld, input logic [31:0] v, input logic [7:0] e);
    exp_t x;
    int d;
    logic [7:0] litm;
    load = ld;
    valor = v;
    en = e;
    @(posedge clk);
    k++;
    d = ((k - 1) / R) % D;
    litm = e;
`ifdef DISPLAY_SCAN_LZB_EN
    for (int i = 1; i < D; i++) begin
      if ((m_shadow >> (4 * i)) == 32'd0) litm[i] = 1'b0;
    end
`endif
    x.k = k;
    x.numero = m_shadow[4*d +: 4];
    x.an = 8'hFF;
    if (litm[d]) x.an[d] = 1'b0;
    x.frame = 1'b0;
    if ((k % FRAME) == 0 && (m_pendiente || ld)) begin
      m_shadow = ld ? v : m_pend;
      m_pendiente = 1'b0;
      x.frame = 1'b1;
    end else if (ld) begin
      m_pend = v;
      m_pendiente = 1'b1;
    end
    x.pendiente = m_pendiente;
    #1;
    sb.push_back(x);
  endtask

  task automatic idle(input int n, input logic [7:0] e = 8'hFF);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, e);
  endtask

  // Advance so that the next applyStimulus call lands on a boundary edge.
  task automatic idleToBoundary();
    while (((k + 1) % FRAME) != 0) idle(1);
  endtask

  task automatic resetCycle();
    @(posedge clk);
    #1;
    sb.push_back(resetExp());
  endtask

  task automatic modelReset();
    k = 0;
    m_shadow = 32'h0;
    m_pend = 32'h0;
    m_pendiente = 1'b0;
  endtask

  // Assert reset between edges and check the outputs clear without a clock.
  task automatic midReset();
    load = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput(resetExp());
    resetCycle();
    #1;
    rst_n = 1'b1;
    modelReset();
  endtask

  initial begin
    tests = 0;
    failures = 0;
    rst_n = 1'b0;
    load = 1'b0;
    valor = 32'h0;
    en = 8'hFF;
    modelReset();

    $display("[TB] reset and scan");
    repeat (3) resetCycle();
    #1;
    rst_n = 1'b1;
    idle(33);

    $display("[TB] load commit");
    applyStimulus(1'b1, 32'h1234ABCD, 8'hFF);
    idle(70);

    $display("[TB] overwrite and boundary collision");
    applyStimulus(1'b1, 32'h11111111, 8'hFF);
    idle(5);
    applyStimulus(1'b1, 32'h22222222, 8'hFF);
    idleToBoundary();
    idle(34);
    idleToBoundary();
    applyStimulus(1'b1, 32'h33333333, 8'hFF);
    idle(34);

    $display("[TB] enable mask");
    idleToBoundary();
    applyStimulus(1'b1, 32'h1234ABCD, 8'hFF);
    idle(40, 8'hAA);
    idle(4);

`ifdef DISPLAY_SCAN_LZB_EN
    $display("[TB] leading-zero blanking");
    idleToBoundary();
    applyStimulus(1'b1, 32'h000000A5, 8'hFF);
    idle(34);
    idleToBoundary();
    applyStimulus(1'b1, 32'h00000000, 8'hFF);
    idle(34);
`endif

    $display("[TB] reset mid-operation");
    while ((k % FRAME) != 18) idle(1);
    applyStimulus(1'b1, 32'h55555555, 8'hFF);
    idle(1);
    midReset();
    idle(40);

    load = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard drain: got %0d entries left expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/display_scan.md
# display_scan

Time-multiplexed scanner for the 8-digit seven-segment display. Holds a 32-bit hex value, selects one nibble at a time and drives it onto `numero` for the `segmentos` decoder directly downstream, while driving the matching active-low anode. New values are double-buffered and committed only at frame boundaries, so a digit never shows a torn value.

## Interface
- `DIGITS`, 8: number of multiplexed digits (1..8); `valor` nibble i maps to digit i.
- `REFRESH_DIV`, 100000: clock cycles each digit stays lit; minimum 2.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `valor`  in  4*DIGITS  hex value to show; nibble 0 (bits 3:0) is the rightmost digit.
- `load`  in  1  single-cycle strobe; captures `valor` into the pending register.
- `en`  in  DIGITS  per-digit enable; 0 forces that digit dark.
- `numero`  out  4  nibble for the current digit, to the `segmentos` decoder.
- `an`  out  DIGITS  anode select, active-low, at most one bit low.
- `frame`  out  1  one-cycle pulse on the cycle the shadow register commits.
- `pendiente`  out  1  high while a loaded value waits for the frame boundary.

## Operation
- Refresh counter `cnt` runs 0..REFRESH_DIV-1 and wraps; `tick` = (`cnt` == REFRESH_DIV-1).
- Digit index `idx` advances on `tick`, wrapping DIGITS-1 -> 0.
- Frame boundary = `tick` && `idx` == DIGITS-1.
- On `load`: `pend` <= `valor`, `pendiente` <= 1. Repeated loads before the boundary overwrite; the last one wins.
- At the frame boundary, if `pendiente` or `load`: `shadow` <= (`load` ? `valor` : `pend`), `pendiente` <= 0, `frame` <= 1. `load` on the boundary cycle itself commits immediately and leaves `pendiente` at 0. With nothing pending, `shadow` holds and `frame` stays 0.
- Outputs are registered from the current state: `numero` <= `shadow`[4*idx +: 4]; `an` <= all ones with bit `idx` cleared when `en[idx]`=1, all ones when `en[idx]`=0.
- `numero` is driven even while the digit is blanked.
- `en` is sampled every cycle; changing it takes effect on the next output update.

## Timing
- Reset (async assert, any cycle, including mid-frame or with a load pending): `cnt`=0, `idx`=0, `shadow`=0, `pend`=0, `pendiente`=0, `frame`=0, `numero`=0, `an`=all ones. A pending value is discarded.
- First rising edge after `rst_n` deasserts: `an` = ~1 (digit 0 low if `en[0]`), `numero`=0.
- Output latency: 1 cycle from an `idx`/`shadow` change to `numero`/`an`.
- Digit period is REFRESH_DIV cycles; frame period is DIGITS*REFRESH_DIV cycles.
- Load-to-display: the committed value appears on digit 0 one cycle after the boundary. Worst case from `load` is DIGITS*REFRESH_DIV+1 cycles.
- `frame` is high exactly one cycle, the cycle after the boundary edge (the same cycle `idx` reads 0).
- `pendiente` rises the cycle after `load` and falls the cycle after the boundary.

## Configuration
- `DISPLAY_SCAN_LZB_EN` defined: leading-zero blanking. Digit i is forced dark (its `an` bit high) when all nibbles of `shadow` from i up to DIGITS-1 are zero, for i>0. Digit 0 is never blanked by this rule. The rule is evaluated on `shadow`, so it follows frame commits and stacks with `en`.
- Undefined: every enabled digit is lit, including leading zeros; no blanking logic is synthesized.

## Test plan
- Reset and scan: DIGITS=8, REFRESH_DIV=4, `en`=FF. Hold reset, release -> `an`=FF under reset, then FE, FD, FB... each held 4 cycles, back to FE after 32 cycles; `numero`=0 throughout.
- Load commit: `load` with `valor`=32'h1234ABCD mid-frame -> `pendiente`=1; at the boundary `frame` pulses once, `pendiente`=0; then `numero` steps D, C, B, A, 4, 3, 2, 1 with `an` FE..7F.
- Overwrite and boundary collision: `load` 32'h11111111, then `load` 32'h22222222 before the boundary -> only 2s shown. `load` 32'h33333333 exactly on the boundary cycle -> 3s shown from digit 0 with `pendiente` never high.
- Enable mask: `en`=8'b1010_1010 -> `an` is FF during digits 0, 2, 4, 6 while `numero` still cycles through the nibbles.
- Reset mid-operation: assert `rst_n`=0 asynchronously with a load pending and `idx`=5 -> `an`=FF and `numero`=0 immediately. After release, the scan restarts at digit 0 showing 0 and no `frame` pulse occurs.
- With `DISPLAY_SCAN_LZB_EN`: `valor`=32'h000000A5 -> only digits 0 and 1 lit. `valor`=0 -> only digit 0 lit, showing 0.
